// File: rtl/check_pkg.sv
// Shared types for the check scheduler: FSM state encoding and checker count width.
// Purely declarative; no timing or flow-control behaviour.
package check_pkg;
  localparam int CHK_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/check_sched_rr_arb.sv
// Round-robin picker: lowest requester index at or after ptr wins, wrapping at N_REQ-1.
// Purely combinational, zero latency; never stalls.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] sel,
  output logic [IW-1:0]    sel_idx,
  output logic             any
);

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % N_REQ]) begin
        any                            = 1'b1;
        sel[(int'(ptr) + k) % N_REQ]   = 1'b1;
        sel_idx                        = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/check_sched.sv
// Shares one serial sequence checker among N_REQ requesters; grant-to-done = W + DRAIN + 2 cycles.
// chk_hold stalls the shift/drain phases indefinitely; requesters wait in round-robin order.
module check_sched
  import check_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int DRAIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 done_hit,
  output logic                 cnt_err,
  output logic                 busy,
  output logic                 chk_clr,
  output logic                 chk_num,
  input  logic                 chk_hold,
  input  logic [CHK_CNT_W-1:0] chk_cnt,
  input  logic                 chk_result
);

  localparam int IW         = $clog2(N_REQ);
  localparam int BW         = $clog2(W + 1);
  localparam int DW         = 3;
  localparam int DRAIN_LAST = (DRAIN > 0) ? DRAIN - 1 : 0;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    idx_q;
  logic [N_REQ-1:0] gnt_q;
  logic [W-1:0]     word_q;
  logic [BW-1:0]    bit_q;
  logic [DW-1:0]    drain_q;
  logic             hit_q;

  logic [N_REQ-1:0] arb_sel;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [W-1:0]     arb_word;

  rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .sel     (arb_sel),
    .sel_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    arb_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == arb_idx) arb_word = req_data[i*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (!chk_hold && bit_q == BW'(W - 1)) state_d = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: if (!chk_hold && drain_q == DW'(DRAIN_LAST)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // word_q doubles as the shift register: its MSB is always the bit on offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      drain_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            idx_q  <= arb_idx;
            gnt_q  <= arb_sel;
            word_q <= arb_word;
          end
        end
        ST_CLEAR: begin
          bit_q   <= '0;
          drain_q <= '0;
          hit_q   <= 1'b0;
        end
        ST_SHIFT: begin
          if (!chk_hold) begin
            bit_q  <= bit_q + 1'b1;
            word_q <= word_q << 1;
          end
          if (chk_result) hit_q <= 1'b1;
        end
        ST_DRAIN: begin
          if (!chk_hold) drain_q <= drain_q + 1'b1;
          if (chk_result) hit_q <= 1'b1;
        end
        ST_DONE: begin
          gnt_q <= '0;
          ptr_q <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    chk_clr  = (state_q == ST_CLEAR);
    chk_num  = (state_q == ST_SHIFT) & word_q[W-1];
    gnt      = gnt_q;
    done     = (state_q == ST_DONE) ? gnt_q : '0;
    done_hit = (state_q == ST_DONE) & hit_q;
    cnt_err  = (state_q == ST_DONE) && (chk_cnt != CHK_CNT_W'(W));
  end

endmodule

// File: tb/tb_check_sched.sv
// Directed bench for check_sched: stubbed checker inputs, hand-computed grant order, bits and latencies.
module tb_check_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        done_hit;
  logic        cnt_err;
  logic        busy;
  logic        chk_clr;
  logic        chk_num;
  logic        chk_hold;
  logic [3:0]  chk_cnt;
  logic        chk_result;

  int checks = 0;
  int errors = 0;

  check_sched #(.N_REQ(4), .W(8), .DRAIN(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .done_hit   (done_hit),
    .cnt_err    (cnt_err),
    .busy       (busy),
    .chk_clr    (chk_clr),
    .chk_num    (chk_num),
    .chk_hold   (chk_hold),
    .chk_cnt    (chk_cnt),
    .chk_result (chk_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Runs one frame starting in the IDLE cycle where the grant is decided (n=0).
  task automatic serve(input int hs, input int hl, input int rs, input int drop,
                       input logic [3:0] cnt_v,
                       output int lat, output logic [3:0] d, output logic h,
                       output logic e, output logic [7:0] bits, output logic stable);
    int   n;
    int   nb;
    logic prev_hold;
    logic prev_num;
    n = 0; nb = 0; prev_hold = 1'b0; prev_num = 1'b0;
    stable = 1'b1; d = '0; h = 1'b0; e = 1'b0; bits = '0; lat = 0;
    chk_cnt = cnt_v;
    while (n < 100 && d == 4'b0) begin
      tick();
      n++;
      if (n == drop) begin
        req      = 4'b0;
        req_data = 32'hFFFF_FFFF;
      end
      chk_hold   = (n >= hs && n < hs + hl);
      chk_result = (n == rs);
      check("chk_clr", 32'(chk_clr), 32'(n == 1));
      check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      if (prev_hold && prev_num !== chk_num) stable = 1'b0;
      if (n >= 2 && nb < 8 && !chk_hold) begin
        bits[7-nb] = chk_num;
        nb++;
      end
      prev_hold = chk_hold;
      prev_num  = chk_num;
      if (done != 4'b0) begin
        d = done; h = done_hit; e = cnt_err; lat = n;
      end
    end
    chk_hold   = 1'b0;
    chk_result = 1'b0;
    check("done_seen", 32'(d != 4'b0), 32'd1);
    tick();
    check("done_single_pulse", 32'(done), 32'd0);
    check("gnt_drop_after_done", 32'(gnt), 32'd0);
  endtask

  logic [7:0] dat [4];
  int         lat;
  logic [3:0] d;
  logic       h, e, stable;
  logic [7:0] bits;

  initial begin
    dat[0] = 8'hA5; dat[1] = 8'h5A; dat[2] = 8'h96; dat[3] = 8'h3C;
    rst = 1'b1; req = '0; req_data = 32'h3C96_5AA5;
    chk_hold = 1'b0; chk_cnt = 4'd8; chk_result = 1'b0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chk_clr", 32'(chk_clr), 32'd0);
    check("rst_chk_num", 32'(chk_num), 32'd0);
    check("rst_done_hit", 32'(done_hit), 32'd0);
    check("rst_cnt_err", 32'(cnt_err), 32'd0);
    rst = 1'b0;

    // Single frame from requester 0, word A5.
    req = 4'b0001;
    check("t1_idle_gnt", 32'(gnt), 32'd0);
    serve(0, 0, 0, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t1_lat", 32'(lat), 32'd12);
    check("t1_done", 32'(d), 32'h1);
    check("t1_hit", 32'(h), 32'd0);
    check("t1_cnt_err", 32'(e), 32'd0);
    check("t1_bits", 32'(bits), 32'hA5);

    // All requesting: rotation 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(0, 0, 0, 0, 4'd8, lat, d, h, e, bits, stable);
      check("t2_done_order", 32'(d), 32'(4'b0001 << (k % 4)));
      check("t2_bits", 32'(bits), 32'(dat[k % 4]));
      check("t2_lat", 32'(lat), 32'd12);
    end

    // Three hold cycles on bit 2.
    do_reset();
    req = 4'b0001;
    serve(4, 3, 0, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t3_lat", 32'(lat), 32'd15);
    check("t3_bits", 32'(bits), 32'hA5);
    check("t3_stable", 32'(stable), 32'd1);
    check("t3_done", 32'(d), 32'h1);

    // Result pulse in first drain cycle, then a clean frame.
    serve(0, 0, 10, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t4_hit_set", 32'(h), 32'd1);
    check("t4_lat", 32'(lat), 32'd12);
    serve(0, 0, 0, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t4_hit_cleared", 32'(h), 32'd0);

    // Short bit count, then reset mid-shift.
    serve(0, 0, 0, 0, 4'd7, lat, d, h, e, bits, stable);
    check("t5_cnt_err", 32'(e), 32'd1);
    check("t5_done", 32'(d), 32'h1);
    chk_cnt = 4'd8;
    req = 4'b1111;
    tick();
    tick();
    tick();
    check("t5_pre_rst_gnt", 32'(gnt), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_gnt", 32'(gnt), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_done", 32'(done), 32'd0);
    check("t5_async_chk_num", 32'(chk_num), 32'd0);
    tick();
    check("t5_in_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    serve(0, 0, 0, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t5_restart_req0", 32'(d), 32'h1);
    check("t5_restart_bits", 32'(bits), 32'hA5);

    // Request and data withdrawn right after grant.
    do_reset();
    req = 4'b0001;
    serve(0, 0, 0, 1, 4'd8, lat, d, h, e, bits, stable);
    check("t6_done", 32'(d), 32'h1);
    check("t6_bits", 32'(bits), 32'hA5);
    check("t6_lat", 32'(lat), 32'd12);

    // Move pointer to 2, then 3 and 1 pending.
    req_data = 32'h3C96_5AA5;
    req = 4'b0010;
    serve(0, 0, 0, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t6_ptr_setup", 32'(d), 32'h2);
    req = 4'b1010;
    serve(0, 0, 0, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t6_first_3", 32'(d), 32'h8);
    check("t6_bits_3", 32'(bits), 32'h3C);
    serve(0, 0, 0, 0, 4'd8, lat, d, h, e, bits, stable);
    check("t6_then_1", 32'(d), 32'h2);
    check("t6_bits_1", 32'(bits), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
